sort_seq: RTL and testbench

- Sequencer for the sort datapath. It holds a DEPTH-entry register array and runs an in-place bubble sort over it, one compare-and-swap per clock.
- Provides load, start/busy/done handshake and asynchronous read-back.
- Instantiated under top, beside the data source that loads it and the sink that reads results.

---
 rtl/sort_pkg.sv | 26 ++
 rtl/cmp_swap.sv | 23 ++
 rtl/sort_seq.sv | 181 ++++++++++++++++++
 tb/tb_sort_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sort_pkg
// Brief    : Shared state encoding, default sizes and a cycle-count helper
//            for the sort sequencer.
// Revision : 1.0  initial release
// ============================================================================
package sort_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  // Number of compare cycles of a full bubble sort over n entries
  function automatic int sort_cycles(input int n);
    return (n * (n - 1)) / 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmp_swap.sv
`default_nettype none
// ============================================================================
// Module   : cmp_swap
// Brief    : Combinational unsigned compare-and-swap; lo/hi are the ordered
//            pair, swap flags a strict a>b (equal values stay put).
// Revision : 1.0  initial release
// ============================================================================
module cmp_swap #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             swap
);

  assign swap = (a > b);
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;

endmodule
`default_nettype wire

// File: rtl/sort_seq.sv
`default_nettype none
// ============================================================================
// Module   : sort_seq
// Brief    : In-place bubble-sort sequencer over a DEPTH-entry register
//            array, one compare-and-swap per clock, with load port,
//            start/busy/done handshake and combinational read-back.
//            Optional macro SORT_EARLY_EXIT_EN ends the sort after the first
//            pass that performs no swap.
// Revision : 1.0  initial release
// ============================================================================
module sort_seq
  import sort_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [15:0]      swap_cnt
);

  localparam int          LAST_I  = (DEPTH >= 2) ? DEPTH - 2 : 0;
  localparam logic [AW:0] C_LAST  = (AW+1)'(LAST_I);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_ONE   = (AW+1)'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] arr_q [DEPTH];
  logic [WIDTH-1:0] arr_d [DEPTH];
  logic [AW:0]      pass_q, pass_d;
  logic [AW:0]      idx_q, idx_d;
  logic [15:0]      swap_cnt_q, swap_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [AW:0]      idx_inc;
  logic [AW-1:0]    ia, ib;
  logic [WIDTH-1:0] cs_lo, cs_hi;
  logic             cs_swap;
  logic             pass_end, last_pass, stop_now;

`ifdef SORT_EARLY_EXIT_EN
  logic             swapped_q, swapped_d;
`endif

  assign idx_inc   = idx_q + C_ONE;
  assign ia        = idx_q[AW-1:0];
  assign ib        = idx_inc[AW-1:0];
  assign pass_end  = (idx_q == (C_LAST - pass_q));
  assign last_pass = (pass_q == C_LAST);

`ifdef SORT_EARLY_EXIT_EN
  // A pass with no swap (including the current compare) means the array is ordered
  assign stop_now = last_pass || !(swapped_q || cs_swap);
`else
  assign stop_now = last_pass;
`endif

  cmp_swap #(.WIDTH(WIDTH)) u_cmp (
    .a    (arr_q[ia]),
    .b    (arr_q[ib]),
    .lo   (cs_lo),
    .hi   (cs_hi),
    .swap (cs_swap)
  );

  assign rd_data  = ({1'b0, rd_addr} < C_DEPTH) ? arr_q[rd_addr] : '0;
  assign busy     = busy_q;
  assign done     = done_q;
  assign swap_cnt = swap_cnt_q;

  // Next-state, array update and registered-output computation
  always_comb begin
    state_d    = state_q;
    arr_d      = arr_q;
    pass_d     = pass_q;
    idx_d      = idx_q;
    swap_cnt_d = swap_cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef SORT_EARLY_EXIT_EN
    swapped_d  = swapped_q;
`endif
    case (state_q)
      IDLE: begin
        if (wr_en && ({1'b0, wr_addr} < C_DEPTH)) begin
          arr_d[wr_addr] = wr_data;
        end
        if (start) begin
          swap_cnt_d = '0;
          pass_d     = '0;
          idx_d      = '0;
`ifdef SORT_EARLY_EXIT_EN
          swapped_d  = 1'b0;
`endif
          if (DEPTH == 1) begin
            // nothing to compare: go straight to the completion pulse
            state_d = FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = SORT;
            busy_d  = 1'b1;
          end
        end
      end
      SORT: begin
        if (cs_swap) begin
          arr_d[ia] = cs_lo;
          arr_d[ib] = cs_hi;
          if (swap_cnt_q != 16'hFFFF) begin
            swap_cnt_d = swap_cnt_q + 16'd1;
          end
        end
        if (pass_end) begin
          idx_d  = '0;
          pass_d = pass_q + C_ONE;
`ifdef SORT_EARLY_EXIT_EN
          swapped_d = 1'b0;
`endif
          if (stop_now) begin
            state_d = FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          idx_d = idx_inc;
`ifdef SORT_EARLY_EXIT_EN
          swapped_d = swapped_q | cs_swap;
`endif
        end
      end
      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, array and output registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      for (int k = 0; k < DEPTH; k++) arr_q[k] <= '0;
      pass_q     <= '0;
      idx_q      <= '0;
      swap_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef SORT_EARLY_EXIT_EN
      swapped_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      arr_q      <= arr_d;
      pass_q     <= pass_d;
      idx_q      <= idx_d;
      swap_cnt_q <= swap_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef SORT_EARLY_EXIT_EN
      swapped_q  <= swapped_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sort_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sort_seq
// Brief    : Directed self-checking bench for sort_seq (DEPTH=8, WIDTH=8).
// Revision : 1.0  initial release
// ============================================================================
module tb_sort_seq;
  import sort_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic             clk;
  logic             rst;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             start;
  logic             busy;
  logic             done;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic [15:0]      swap_cnt;

  int n_cmp;
  int n_bad;

  sort_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .swap_cnt (swap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Write eight entries, one per clock, starting at a falling edge
  task automatic load(input logic [WIDTH-1:0] v [8]);
    for (int k = 0; k < 8; k++) begin
      wr_en   = 1'b1;
      wr_addr = AW'(k);
      wr_data = v[k];
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  task automatic check_array(input string tag, input logic [WIDTH-1:0] v [8]);
    for (int k = 0; k < 8; k++) begin
      rd_addr = AW'(k);
      #1;
      chk($sformatf("%s[%0d]", tag, k), 32'(rd_data), 32'(v[k]));
    end
  endtask

  // Pulse start, then watch a fixed window counting busy cycles and done
  // pulses; optionally poke a write and a start mid-sort.
  task automatic run_sort(input bit inject, output int nbusy, output int ndone);
    nbusy = 0;
    ndone = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < sort_cycles(DEPTH) + 10; k++) begin
      if (busy) nbusy++;
      if (done) ndone++;
      if (inject && k == 5) begin
        wr_en = 1'b1; wr_addr = '0; wr_data = 8'hFF; start = 1'b1;
      end else begin
        wr_en = 1'b0; start = 1'b0;
      end
      @(negedge clk);
    end
    wr_en = 1'b0;
    start = 1'b0;
  endtask

  logic [WIDTH-1:0] v_mix [8] = '{8'd5, 8'd3, 8'd7, 8'd1, 8'd8, 8'd2, 8'd6, 8'd4};
  logic [WIDTH-1:0] v_rev [8] = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
  logic [WIDTH-1:0] v_asc [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
  logic [WIDTH-1:0] v_dup [8] = '{8'd3, 8'd3, 8'd1, 8'd1, 8'd2, 8'd2, 8'd0, 8'd0};
  logic [WIDTH-1:0] v_dsr [8] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3};
  logic [WIDTH-1:0] v_zro [8] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};

`ifdef SORT_EARLY_EXIT_EN
  // passes needed: mix 4 swapping passes + 1 clean (7+6+5+4+3), sorted 1 clean pass
  localparam int CYC_MIX = 25;
  localparam int CYC_ASC = 7;
`else
  localparam int CYC_MIX = 28;
  localparam int CYC_ASC = 28;
`endif
  localparam int CYC_FULL = 28;

  initial begin
    int nb;
    int nd;
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; rd_addr = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_swap", 32'(swap_cnt), 32'd0);
    chk("rst_rd0", 32'(rd_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // mixed data: 14 inversions
    load(v_mix);
    run_sort(1'b0, nb, nd);
    chk("mix_busy", 32'(nb), 32'(CYC_MIX));
    chk("mix_done", 32'(nd), 32'd1);
    chk("mix_swap", 32'(swap_cnt), 32'd14);
    check_array("mix", v_asc);

    // reverse data: every pair inverted
    @(negedge clk);
    load(v_rev);
    run_sort(1'b0, nb, nd);
    chk("rev_busy", 32'(nb), 32'(CYC_FULL));
    chk("rev_done", 32'(nd), 32'd1);
    chk("rev_swap", 32'(swap_cnt), 32'd28);
    check_array("rev", v_asc);

    // already sorted
    @(negedge clk);
    load(v_asc);
    run_sort(1'b0, nb, nd);
    chk("asc_busy", 32'(nb), 32'(CYC_ASC));
    chk("asc_done", 32'(nd), 32'd1);
    chk("asc_swap", 32'(swap_cnt), 32'd0);
    check_array("asc", v_asc);

    // duplicates, with a write and a start poked while busy
    @(negedge clk);
    load(v_dup);
    run_sort(1'b1, nb, nd);
    chk("dup_busy", 32'(nb), 32'(CYC_FULL));
    chk("dup_done", 32'(nd), 32'd1);
    chk("dup_swap", 32'(swap_cnt), 32'd20);
    check_array("dup", v_dsr);

    // reset in the middle of a sort
    @(negedge clk);
    load(v_rev);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_swap", 32'(swap_cnt), 32'd0);
    check_array("abort", v_zro);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load(v_mix);
    run_sort(1'b0, nb, nd);
    chk("post_busy", 32'(nb), 32'(CYC_MIX));
    chk("post_done", 32'(nd), 32'd1);
    chk("post_swap", 32'(swap_cnt), 32'd14);
    check_array("post", v_asc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
